mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 No parameters; channel count fixed at 31 (sel 0..30), data width fixed at 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  scan request, sampled in IDLE only.
REQ-005 mask  input  31  channel enable, bit i = channel i; sampled on the accepted start.
REQ-006 mux_out  input  2  selected data returned by the downstream 31:1 mux.
REQ-007 dout_ready  input  1  consumer ready for the current dout beat.
REQ-008 sel  output  5  channel select driven to the mux.
REQ-009 dout_valid  output  1  dout_data/dout_chan valid.
REQ-010 dout_data  output  2  captured mux_out for dout_chan.
REQ-011 dout_chan  output  5  channel index of dout_data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at scan end.

Function
REQ-014 FSM states: IDLE, SETTLE, EMIT, DONE; all outputs registered.
REQ-015 IDLE: on start=1, latch mask into mask_q; if mask is nonzero, set sel to the lowest set bit index and go to SETTLE; otherwise go directly to DONE.
REQ-016 SETTLE: lasts exactly one cycle; at its end, capture mux_out into dout_data, copy sel into dout_chan, assert dout_valid, and go to EMIT.
REQ-017 EMIT: dout_valid, dout_data and dout_chan hold stable until a cycle with dout_ready=1.
REQ-018 EMIT with dout_ready=1: clear dout_valid; if a set bit of mask_q exists above sel, load sel with the next such index and go to SETTLE; otherwise go to DONE.
REQ-019 DONE: assert done for exactly one cycle, then go to IDLE; sel holds its last value.
REQ-020 Latency: start to first dout_valid is 2 cycles; ready handshake to the next dout_valid is 2 cycles.
REQ-021 Ascending order only; masked channels are skipped with zero added cycles; channel 30 is the last possible; sel never takes value 31.
REQ-022 start while busy is ignored; mask changes while busy have no effect.
REQ-023 dout_ready outside EMIT is ignored.

Reset
REQ-024 On reset assertion, asynchronously: state=IDLE, sel=0, dout_valid=0, dout_data=0, dout_chan=0, busy=0, done=0, mask_q=0.
REQ-025 Reset mid-scan abandons the scan; no done pulse is emitted, and the first post-reset cycle accepts a new start.

Configuration
REQ-026 Macro SCAN_CHECKSUM_EN: when defined, add output checksum[6:0], the unsigned sum of all dout_data values accepted (valid and ready) in the current scan.
REQ-027 With SCAN_CHECKSUM_EN: checksum is cleared on the accepted start and on reset, and holds its final value from the done pulse until the next start; the maximum value is 93, with no wrap.
REQ-028 Without SCAN_CHECKSUM_EN: the checksum port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 mask=all ones, dout_ready=1, mux_out=sel[1:0] -> 31 beats with chan 0..30, data=chan%4, done one cycle after the chan-30 handshake.
REQ-030 mask=0x0000_0005, start -> beats at chan 0 and chan 2 only; busy drops after the done pulse.
REQ-031 mask=0, start -> no dout_valid; done pulses 2 cycles after start; busy high for exactly 1 cycle.
REQ-032 dout_ready held low 5 cycles at chan 3 -> dout_valid, data and chan stable for all 5 cycles; chan 4 appears 2 cycles after ready rises.
REQ-033 reset asserted while in EMIT at chan 7 -> all outputs reach reset values immediately; no done pulse; a start 1 cycle later begins at the lowest set channel.
REQ-034 SCAN_CHECKSUM_EN, mask=all ones, mux_out=3 -> checksum=93 at done; a start while busy changes nothing.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 31:1 mux: walks the enabled channels in ascending order and streams each captured sample through a valid/ready port.
// Optional feature: define SCAN_CHECKSUM_EN to add a per-scan checksum of accepted data beats.
module mux_scan_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [30:0] mask,
  input  logic [1:0]  mux_out,
  input  logic        dout_ready,
  output logic [4:0]  sel,
  output logic        dout_valid,
  output logic [1:0]  dout_data,
  output logic [4:0]  dout_chan,
  output logic        busy,
  output logic        done
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [6:0]  checksum
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;

  state_t      state_reg;
  logic [30:0] mask_q;
  logic [30:0] above;

  // Enabled channels strictly above the current select; the lowest of these is next.
  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_above
      assign above[gi] = mask_q[gi] && (sel < 5'(gi));
    end
  endgenerate

  function automatic logic [4:0] lowest_idx(input logic [30:0] v);
    lowest_idx = 5'd0;
    for (int i = 30; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[4:0];
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mask_q     <= '0;
      sel        <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_chan  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mask_q <= mask;
            busy   <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
            checksum <= '0;
`endif
            if (|mask) begin
              sel       <= lowest_idx(mask);
              state_reg <= SETTLE;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        SETTLE: begin
          // The mux has had one full cycle to follow sel; sample it now.
          dout_data  <= mux_out;
          dout_chan  <= sel;
          dout_valid <= 1'b1;
          state_reg  <= EMIT;
        end
        EMIT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
            checksum <= checksum + 7'(dout_data);
`endif
            if (|above) begin
              sel       <= lowest_idx(above);
              state_reg <= SETTLE;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          // The pulse is registered on the way out, so it lands in the first idle cycle.
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
